// File: rtl/gpr_operand_fetch.sv
// Operand fetch stage: GPR read-port drive, x0/write-back bypass, 2-entry skid buffer to EX.
// Optional pending-register scoreboard enabled by defining GPR_OF_SCOREBOARD_EN.
module gpr_operand_fetch #(
  parameter int CTRL_W = 16,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_we,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        reg_read_addr_1,
  input  logic [31:0]       reg_read_data_1,
  output logic [4:0]        reg_read_addr_2,
  input  logic [31:0]       reg_read_data_2,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1Val;
    logic [XLEN-1:0]   rs2Val;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rdWe;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  function automatic logic [XLEN-1:0] resolveOperand(
    input logic [4:0]      src,
    input logic [31:0]     rdata,
    input logic            wbEn,
    input logic [4:0]      wbAddr,
    input logic [XLEN-1:0] wbData
  );
    if (src == 5'd0) begin
      return '0;
    end else if (wbEn && (wbAddr == src)) begin
      return wbData;
    end else begin
      return XLEN'(rdata);
    end
  endfunction

  // Held operands pick up a committing write so a stalled entry never carries a stale value.
  function automatic entry_t snoopEntry(
    input entry_t          e,
    input logic            wbEn,
    input logic [4:0]      wbAddr,
    input logic [XLEN-1:0] wbData
  );
    entry_t r;
    r = e;
    if (wbEn && (wbAddr != 5'd0)) begin
      if (e.rs1 == wbAddr) r.rs1Val = wbData;
      if (e.rs2 == wbAddr) r.rs2Val = wbData;
    end
    return r;
  endfunction

  entry_t mainEntry_q, mainEntry_d;
  entry_t skidEntry_q, skidEntry_d;
  logic   mainValid_q, mainValid_d;
  logic   skidValid_q, skidValid_d;

  entry_t incoming;
  entry_t mainSnoop;
  entry_t skidSnoop;
  logic   hazardFree;
  logic   accept;
  logic   pop;

  assign reg_read_addr_1 = in_rs1;
  assign reg_read_addr_2 = in_rs2;

`ifdef GPR_OF_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;
  logic        rs1Busy;
  logic        rs2Busy;

  // A source is busy while its producer is in flight, unless the write lands this very cycle.
  always_comb begin
    rs1Busy    = pending_q[in_rs1] && !(wb_en && (wb_addr == in_rs1));
    rs2Busy    = pending_q[in_rs2] && !(wb_en && (wb_addr == in_rs2));
    hazardFree = !rs1Busy && !rs2Busy;
  end

  // Set is applied after clear so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wb_en) pending_d[wb_addr] = 1'b0;
      if (accept && in_rd_we && (in_rd != 5'd0)) pending_d[in_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign hazardFree = 1'b1;
`endif

  assign in_ready = rst_n && !skidValid_q && hazardFree;
  assign accept   = in_valid && in_ready;
  assign pop      = mainValid_q && out_ready;

  always_comb begin
    incoming.pc     = in_pc;
    incoming.imm    = in_imm;
    incoming.rs1    = in_rs1;
    incoming.rs2    = in_rs2;
    incoming.rd     = in_rd;
    incoming.rdWe   = in_rd_we;
    incoming.ctrl   = in_ctrl;
    incoming.rs1Val = resolveOperand(in_rs1, reg_read_data_1, wb_en, wb_addr, wb_data);
    incoming.rs2Val = resolveOperand(in_rs2, reg_read_data_2, wb_en, wb_addr, wb_data);
    mainSnoop       = snoopEntry(mainEntry_q, wb_en && mainValid_q, wb_addr, wb_data);
    skidSnoop       = snoopEntry(skidEntry_q, wb_en && skidValid_q, wb_addr, wb_data);
  end

  // Flush beats pop and accept; SKID only fills when MAIN is full and not draining.
  always_comb begin
    mainEntry_d = mainSnoop;
    skidEntry_d = skidSnoop;
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      mainEntry_d = mainEntry_q;
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (pop) begin
      if (skidValid_q) begin
        mainEntry_d = skidSnoop;
        skidValid_d = 1'b0;
      end else if (accept) begin
        mainEntry_d = incoming;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!mainValid_q) begin
        mainEntry_d = incoming;
        mainValid_d = 1'b1;
      end else begin
        skidEntry_d = incoming;
        skidValid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mainEntry_q <= '0;
      skidEntry_q <= '0;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
    end
  end

  assign out_valid   = mainValid_q;
  assign out_pc      = mainEntry_q.pc;
  assign out_imm     = mainEntry_q.imm;
  assign out_rs1_val = mainEntry_q.rs1Val;
  assign out_rs2_val = mainEntry_q.rs2Val;
  assign out_rd      = mainEntry_q.rd;
  assign out_rd_we   = mainEntry_q.rdWe;
  assign out_ctrl    = mainEntry_q.ctrl;

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Directed bench for gpr_operand_fetch; scoreboard steps compile in with GPR_OF_SCOREBOARD_EN.
module tb_gpr_operand_fetch;

  localparam int CTRL_W = 16;
  localparam int XLEN   = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_rd_we;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        reg_read_addr_1;
  logic [31:0]       reg_read_data_1;
  logic [4:0]        reg_read_addr_2;
  logic [31:0]       reg_read_data_2;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [4:0]        out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;

  logic [31:0] gpr [32];
  int total = 0;
  int bad   = 0;

  gpr_operand_fetch #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .reg_read_addr_1(reg_read_addr_1), .reg_read_data_1(reg_read_data_1),
    .reg_read_addr_2(reg_read_addr_2), .reg_read_data_2(reg_read_data_2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file reads old contents; the write lands at the edge, so same-cycle reads need bypass.
  assign reg_read_data_1 = gpr[reg_read_addr_1];
  assign reg_read_data_2 = gpr[reg_read_addr_2];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic we);
    in_valid = v;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
    in_imm   = pc + 32'h10;
    in_ctrl  = pc[15:0] ^ 16'hA5A5;
  endtask

  task automatic setWb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (wb_en && (wb_addr != 5'd0)) gpr[wb_addr] = wb_data;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + i;
    gpr[0]  = 32'h0;
    gpr[3]  = 32'h33;
    gpr[5]  = 32'h11;
    gpr[6]  = 32'h22;
    gpr[7]  = 32'h70;
    gpr[9]  = 32'h90;
    gpr[10] = 32'hA0;
    gpr[11] = 32'hB0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    setWb(1'b0, 5'd0, 32'h0);

    // reset
    stepClock();
    stepClock();
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_pc", {32'd0, out_pc}, 64'd0);
    checkOutput("rst_out_rs1", {32'd0, out_rs1_val}, 64'd0);
    checkOutput("rst_out_ctrl", {48'd0, out_ctrl}, 64'd0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // basic accept, latency 1
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h100, 5'd5, 5'd6, 5'd1, 1'b1);
    #1;
    checkOutput("read_addr_1", {59'd0, reg_read_addr_1}, 64'd5);
    checkOutput("read_addr_2", {59'd0, reg_read_addr_2}, 64'd6);
    stepClock();
    checkOutput("t1_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_rs1", {32'd0, out_rs1_val}, 64'h11);
    checkOutput("t1_rs2", {32'd0, out_rs2_val}, 64'h22);
    checkOutput("t1_pc", {32'd0, out_pc}, 64'h100);
    checkOutput("t1_imm", {32'd0, out_imm}, 64'h110);
    checkOutput("t1_rd", {58'd0, out_rd, out_rd_we}, {58'd0, 5'd1, 1'b1});
    checkOutput("t1_ctrl", {48'd0, out_ctrl}, 64'hA4A5);

    // x0 never bypasses; same-cycle write-back does
    applyStimulus(1'b1, 32'h104, 5'd0, 5'd6, 5'd0, 1'b0);
    setWb(1'b1, 5'd0, 32'hFF);
    stepClock();
    checkOutput("x0_rs1", {32'd0, out_rs1_val}, 64'h0);
    checkOutput("x0_rs2", {32'd0, out_rs2_val}, 64'h22);
    checkOutput("x0_pc", {32'd0, out_pc}, 64'h104);
    applyStimulus(1'b1, 32'h108, 5'd7, 5'd0, 5'd0, 1'b0);
    setWb(1'b1, 5'd7, 32'hAB);
    stepClock();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("byp_rs1", {32'd0, out_rs1_val}, 64'hAB);
    checkOutput("byp_rs2", {32'd0, out_rs2_val}, 64'h0);
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    stepClock();
    checkOutput("drain_valid", {63'd0, out_valid}, 64'd0);

    // skid fill and ordered drain
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h200, 5'd10, 5'd11, 5'd0, 1'b0);
    stepClock();
    checkOutput("c_pc", {32'd0, out_pc}, 64'h200);
    checkOutput("c_ops", {out_rs1_val, out_rs2_val}, {32'hA0, 32'hB0});
    checkOutput("c_in_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(1'b1, 32'h204, 5'd5, 5'd6, 5'd0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("skid_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("skid_hold_pc", {32'd0, out_pc}, 64'h200);
    out_ready = 1'b1;
    stepClock();
    checkOutput("d_pc", {32'd0, out_pc}, 64'h204);
    checkOutput("d_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("d_rs1", {32'd0, out_rs1_val}, 64'h11);
    checkOutput("d_in_ready", {63'd0, in_ready}, 64'd1);
    stepClock();
    checkOutput("d_drained", {63'd0, out_valid}, 64'd0);

    // snoop of stalled MAIN and of SKID
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h300, 5'd5, 5'd9, 5'd0, 1'b0);
    stepClock();
    checkOutput("e_rs2_before", {32'd0, out_rs2_val}, 64'h90);
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    setWb(1'b1, 5'd9, 32'h1234);
    stepClock();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("e_rs2_snoop", {32'd0, out_rs2_val}, 64'h1234);
    checkOutput("e_rs1_keep", {32'd0, out_rs1_val}, 64'h11);
    checkOutput("e_valid", {63'd0, out_valid}, 64'd1);
    applyStimulus(1'b1, 32'h304, 5'd9, 5'd3, 5'd0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    setWb(1'b1, 5'd3, 32'h5555);
    stepClock();
    setWb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    stepClock();
    checkOutput("f_pc", {32'd0, out_pc}, 64'h304);
    checkOutput("f_ops", {out_rs1_val, out_rs2_val}, {32'h1234, 32'h5555});

    // flush with MAIN+SKID full, then flush discarding a same-cycle accept
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h400, 5'd5, 5'd6, 5'd0, 1'b0);
    stepClock();
    checkOutput("g_in_ready", {63'd0, in_ready}, 64'd0);
    applyStimulus(1'b1, 32'h404, 5'd5, 5'd6, 5'd0, 1'b0);
    flush = 1'b1;
    stepClock();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    stepClock();
    checkOutput("flush_stays_empty", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h500, 5'd5, 5'd6, 5'd0, 1'b0);
    stepClock();
    checkOutput("i_pc", {32'd0, out_pc}, 64'h500);
    applyStimulus(1'b1, 32'h504, 5'd5, 5'd6, 5'd0, 1'b0);
    flush = 1'b1;
    stepClock();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("flush2_valid", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b1, 32'h600, 5'd5, 5'd6, 5'd0, 1'b0);
    out_ready = 1'b1;
    stepClock();
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("k_pc", {32'd0, out_pc}, 64'h600);
    checkOutput("k_valid", {63'd0, out_valid}, 64'd1);
    stepClock();
    checkOutput("k_drained", {63'd0, out_valid}, 64'd0);

`ifdef GPR_OF_SCOREBOARD_EN
    // pending producer blocks a dependent until its write-back
    applyStimulus(1'b1, 32'h700, 5'd5, 5'd6, 5'd3, 1'b1);
    stepClock();
    applyStimulus(1'b1, 32'h704, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput("sb_block", {63'd0, in_ready}, 64'd0);
    stepClock();
    checkOutput("sb_not_accepted", {63'd0, out_valid}, 64'd0);
    checkOutput("sb_still_block", {63'd0, in_ready}, 64'd0);
    setWb(1'b1, 5'd3, 32'h7777);
    #1;
    checkOutput("sb_release", {63'd0, in_ready}, 64'd1);
    stepClock();
    setWb(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("sb_m_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("sb_m_pc", {32'd0, out_pc}, 64'h704);
    checkOutput("sb_m_rs1", {32'd0, out_rs1_val}, 64'h7777);
`else
    // without the bitmap a dependent is never held back here
    applyStimulus(1'b1, 32'h700, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput("nosb_ready", {63'd0, in_ready}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("nosb_rs1", {32'd0, out_rs1_val}, 64'h5555);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
